seg_scan_decoder: RTL and testbench
===================================

Name: seg_scan_decoder

Overview:
- Receive end of the seven-segment display interface: samples an externally time-multiplexed display (digit-select plus segment lines, e.g. on GPIO_0) and turns it back into characters.
- Filters each strobed digit for stability, decodes the 7-bit segment pattern to ASCII, and holds a per-digit character register file.
- Reports changes and loss of scan activity, so the board top can mirror, compare or log what another board is displaying.

Parameters:
- DIGITS, 6, number of multiplexed digit positions (1..8).
- ACTIVE_LOW, 1, 1 = scan_sel and scan_seg are active-low on the pins; 0 = active-high.
- STABLE_CYCLES, 4, consecutive identical samples required to accept a digit (>=2).
- TIMEOUT, 50000, cycles without an accepted digit before lost asserts (1 ms at 50 MHz).

Ports:
- CLOCK_50  input  1  system clock, 50 MHz.
- RESET_N  input  1  asynchronous active-low reset.
- scan_sel  input  DIGITS  digit strobes, asynchronous to CLOCK_50, one-hot when valid.
- scan_seg  input  7  segment lines: bit0=a, bit1=b, bit2=c, bit3=d, bit4=e, bit5=f, bit6=g; asynchronous.
- chars  output  8*DIGITS  decoded ASCII per digit; digit i occupies bits [8i+7:8i].
- valid  output  DIGITS  digit i has been accepted since reset or the last loss.
- upd  output  1  one-cycle pulse: a stored character was written with a new value.
- upd_idx  output  3  index of the digit written when upd=1; holds otherwise.
- lost  output  1  no digit accepted for TIMEOUT cycles, or none since reset.

Behaviour:

Reset (RESET_N low, asynchronous):
- chars = 0x20 in every byte; valid = 0; upd = 0; upd_idx = 0; lost = 1.
- Synchronizers, run counter and timeout counter are cleared.

Input conditioning:
- scan_sel and scan_seg each pass through a 2-flop synchronizer.
- When ACTIVE_LOW=1, both are inverted after synchronization. All logic below sees active-high sel/seg.

Stability filter:
- Registered previous sample {psel, pseg} and a run counter, run, saturating at STABLE_CYCLES.
- If sel is not exactly one-hot (zero or multiple bits set): run = 0.
- Else if {sel, seg} == {psel, pseg}: run = run + 1, saturating.
- Else: run = 1.
- Acceptance occurs in exactly one cycle per stable run: the cycle in which run goes from STABLE_CYCLES-1 to STABLE_CYCLES. It does not repeat while saturated.
- A glitch of one sample restarts the run.

Decode (combinational on accepted seg, {g..a} hex -> ASCII):
- Digits: 3F '0', 06 '1', 5B '2', 4F '3', 66 '4', 6D '5', 7D '6', 07 '7', 7F '8', 6F '9'.
- Letters: 77 'A', 7C 'b', 39 'C', 5E 'd', 79 'E', 71 'F', 76 'H', 38 'L', 54 'n', 73 'P', 78 't', 3E 'U', 6E 'y'.
- 00 -> ' '. Any other pattern -> '?'.
- 6D decodes as '5' (the S/5 ambiguity resolves to the digit).

Register update (cycle after acceptance):
- Index i = position of the set bit in sel; chars[i] = decode; valid[i] = 1.
- upd = 1 and upd_idx = i if the decoded value differs from the stored value or valid[i] was 0. Otherwise upd = 0.
- End-to-end latency, pin to chars: 2 (sync) + STABLE_CYCLES + 1 cycles.

Timeout:
- Counter clears on each acceptance and otherwise increments, saturating at TIMEOUT.
- On reaching TIMEOUT: lost = 1 and valid = 0. chars keep their last values.
- The first acceptance after loss clears lost in the same cycle the register is written.
- Acceptance and timeout in the same cycle: acceptance wins; the counter clears and lost stays 0.

Other rules:
- Leaving and returning to a digit with the same pattern re-accepts it, but gives upd = 0.
- Reset mid-run discards the partial run. No character is written.

Test Plan:
- Reset then idle (all pins high, ACTIVE_LOW=1) -> chars all 0x20, valid=0, lost=1; after 50000 more cycles still lost=1, upd never pulses.
- Scan 6 digits, each held 20 cycles, patterns 77,38,37(unknown),77,78,6E -> chars = 'A','L','?','A','t','y'. Six upd pulses, upd_idx 0..5 in scan order, valid=3F, lost=0. First write occurs 7 cycles after the digit-0 pin edge.
- Repeat the identical scan frame -> no upd pulses; chars unchanged.
- Digit 2 held 20 cycles with a single-cycle seg glitch to 7F every 3 cycles -> never accepted; chars[2] unchanged.
- Two sel bits low simultaneously for 30 cycles -> no acceptance; the timeout counter keeps running.
- Stop scanning after a full frame -> lost=1 and valid=0 exactly TIMEOUT cycles after the last acceptance, chars retained. Resume with digit 0 = 3F -> lost=0, chars[0]='0', upd=1, upd_idx=0.
- Assert RESET_N low at run=3 -> all outputs at reset values immediately; no write follows release.

Source files
------------

// File: rtl/seg_scan_if.sv
// Scan-side pins and recovered-character outputs of the 7-segment receiver.
// master = the display being sampled; slave = the decoder.
interface seg_scan_if #(
  parameter int DIGITS = 6
);
  logic [DIGITS-1:0]   scan_sel;
  logic [6:0]          scan_seg;
  logic [8*DIGITS-1:0] chars;
  logic [DIGITS-1:0]   valid;
  logic                upd;
  logic [2:0]          upd_idx;
  logic                lost;

  modport master (
    output scan_sel,
    output scan_seg,
    input  chars,
    input  valid,
    input  upd,
    input  upd_idx,
    input  lost
  );

  modport slave (
    input  scan_sel,
    input  scan_seg,
    output chars,
    output valid,
    output upd,
    output upd_idx,
    output lost
  );
endinterface

// File: rtl/seg_scan_decoder.sv
// Samples a multiplexed 7-segment scan, filters each digit strobe for
// stability, decodes it to ASCII and tracks changes and loss of activity.
module seg_scan_decoder #(
  parameter int DIGITS        = 6,
  parameter bit ACTIVE_LOW    = 1'b1,
  parameter int STABLE_CYCLES = 4,
  parameter int TIMEOUT       = 50000
) (
  input logic      CLOCK_50,
  input logic      RESET_N,
  seg_scan_if.slave bus
);

  localparam int RW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [RW-1:0] RUN_MAX = RW'(STABLE_CYCLES);
  localparam logic [RW-1:0] RUN_ACC = RW'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  logic [DIGITS-1:0]   r_sel_s1;
  logic [DIGITS-1:0]   r_sel_s2;
  logic [6:0]          r_seg_s1;
  logic [6:0]          r_seg_s2;
  logic [DIGITS-1:0]   r_psel;
  logic [6:0]          r_pseg;
  logic [RW-1:0]       r_run;
  logic                r_acc;
  logic [2:0]          r_acc_idx;
  logic [7:0]          r_acc_chr;
  logic [8*DIGITS-1:0] r_chars;
  logic [DIGITS-1:0]   r_valid;
  logic                r_upd;
  logic [2:0]          r_upd_idx;
  logic                r_lost;
  logic [TW-1:0]       r_to_cnt;

  logic [DIGITS-1:0] w_sel;
  logic [6:0]        w_seg;
  logic              w_onehot;
  logic              w_same;
  logic [RW-1:0]     w_run_nxt;
  logic              w_acc;
  logic [2:0]        w_idx;
  logic [7:0]        w_chr;
  logic [7:0]        w_old;
  logic              w_changed;

  function automatic logic [7:0] seg2ascii(input logic [6:0] s);
    logic [7:0] c;
    case (s)
      7'h3F:   c = "0";
      7'h06:   c = "1";
      7'h5B:   c = "2";
      7'h4F:   c = "3";
      7'h66:   c = "4";
      7'h6D:   c = "5";
      7'h7D:   c = "6";
      7'h07:   c = "7";
      7'h7F:   c = "8";
      7'h6F:   c = "9";
      7'h77:   c = "A";
      7'h7C:   c = "b";
      7'h39:   c = "C";
      7'h5E:   c = "d";
      7'h79:   c = "E";
      7'h71:   c = "F";
      7'h76:   c = "H";
      7'h38:   c = "L";
      7'h54:   c = "n";
      7'h73:   c = "P";
      7'h78:   c = "t";
      7'h3E:   c = "U";
      7'h6E:   c = "y";
      7'h00:   c = " ";
      default: c = "?";
    endcase
    return c;
  endfunction

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_sel_s1 <= '0;
      r_sel_s2 <= '0;
      r_seg_s1 <= '0;
      r_seg_s2 <= '0;
    end else begin
      r_sel_s1 <= bus.scan_sel;
      r_sel_s2 <= r_sel_s1;
      r_seg_s1 <= bus.scan_seg;
      r_seg_s2 <= r_seg_s1;
    end
  end

  assign w_sel = ACTIVE_LOW ? ~r_sel_s2 : r_sel_s2;
  assign w_seg = ACTIVE_LOW ? ~r_seg_s2 : r_seg_s2;

  assign w_onehot = (w_sel != '0) &&
                    ((w_sel & (w_sel - 1'b1)) == '0);
  assign w_same   = (w_sel == r_psel) && (w_seg == r_pseg);

  always_comb begin
    w_run_nxt = '0;
    if (!w_onehot)
      w_run_nxt = '0;
    else if (w_same)
      w_run_nxt = (r_run == RUN_MAX) ? RUN_MAX : r_run + 1'b1;
    else
      w_run_nxt = RW'(1);
  end

  // Fires once per stable run: only on the step into saturation.
  assign w_acc = w_onehot && w_same && (r_run == RUN_ACC);

  always_comb begin
    w_idx = '0;
    for (int i = 0; i < DIGITS; i++)
      if (w_sel[i]) w_idx = 3'(i);
  end

  assign w_chr = seg2ascii(w_seg);

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_psel    <= '0;
      r_pseg    <= '0;
      r_run     <= '0;
      r_acc     <= 1'b0;
      r_acc_idx <= '0;
      r_acc_chr <= 8'h20;
    end else begin
      r_psel    <= w_sel;
      r_pseg    <= w_seg;
      r_run     <= w_run_nxt;
      r_acc     <= w_acc;
      if (w_acc) begin
        r_acc_idx <= w_idx;
        r_acc_chr <= w_chr;
      end
    end
  end

  assign w_old     = r_chars[int'(r_acc_idx)*8 +: 8];
  assign w_changed = (w_old != r_acc_chr) || !r_valid[r_acc_idx];

  // A pending write always beats the timeout in the same cycle.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_chars   <= {DIGITS{8'h20}};
      r_valid   <= '0;
      r_upd     <= 1'b0;
      r_upd_idx <= '0;
      r_lost    <= 1'b1;
      r_to_cnt  <= '0;
    end else begin
      r_upd <= 1'b0;
      if (r_acc) begin
        r_chars[int'(r_acc_idx)*8 +: 8] <= r_acc_chr;
        r_valid[r_acc_idx] <= 1'b1;
        r_lost   <= 1'b0;
        r_to_cnt <= '0;
        if (w_changed) begin
          r_upd     <= 1'b1;
          r_upd_idx <= r_acc_idx;
        end
      end else if (r_to_cnt != TO_MAX) begin
        r_to_cnt <= r_to_cnt + 1'b1;
        if (r_to_cnt == TO_LAST) begin
          r_lost  <= 1'b1;
          r_valid <= '0;
        end
      end
    end
  end

  assign bus.chars   = r_chars;
  assign bus.valid   = r_valid;
  assign bus.upd     = r_upd;
  assign bus.upd_idx = r_upd_idx;
  assign bus.lost    = r_lost;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: scan frames, glitches, timeout, reset.
// Pins are active-low; inputs change 1 time unit after each rising edge.
module tb_seg_scan_decoder;

  localparam int D  = 6;
  localparam int ST = 4;
  localparam int TO = 2000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   compared = 0;
  int   mismatched = 0;
  int   upd_cnt = 0;
  int   idx_log[$];

  seg_scan_if #(.DIGITS(D)) bus ();

  seg_scan_decoder #(
    .DIGITS(D), .ACTIVE_LOW(1'b1),
    .STABLE_CYCLES(ST), .TIMEOUT(TO)
  ) dut (
    .CLOCK_50(clk),
    .RESET_N(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (bus.upd === 1'b1) begin
      upd_cnt++;
      idx_log.push_back(int'(bus.upd_idx));
    end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pins(input int d, input logic [6:0] seg);
    logic [D-1:0] s;
    s = '0;
    if (d >= 0) s[d] = 1'b1;
    bus.scan_sel = ~s;
    bus.scan_seg = ~seg;
  endtask

  task automatic idle();
    bus.scan_sel = '1;
    bus.scan_seg = '1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic frame();
    logic [6:0] pat [6];
    pat = '{7'h77, 7'h38, 7'h37, 7'h77, 7'h78, 7'h6E};
    for (int d = 0; d < D; d++) begin
      pins(d, pat[d]);
      tick(20);
    end
    idle();
    tick(10);
  endtask

  localparam logic [47:0] FRAME_CHARS = 48'h7974_413F_4C41;
  localparam logic [47:0] BLANK       = {6{8'h20}};

  initial begin
    int base;
    idle();
    rst_n = 1'b0;
    tick(3);
    check("rst_chars", 64'(bus.chars), 64'(BLANK));
    check("rst_valid", 64'(bus.valid), 64'(0));
    check("rst_lost", 64'(bus.lost), 64'(1));
    check("rst_upd", 64'(bus.upd), 64'(0));
    check("rst_upd_idx", 64'(bus.upd_idx), 64'(0));
    rst_n = 1'b1;

    tick(TO + 20);
    check("idle_lost", 64'(bus.lost), 64'(1));
    check("idle_valid", 64'(bus.valid), 64'(0));
    check("idle_chars", 64'(bus.chars), 64'(BLANK));
    check("idle_upd_cnt", 64'(upd_cnt), 64'(0));

    pins(0, 7'h77);
    tick(6);
    check("lat_before", 64'(bus.chars[7:0]), 64'(8'h20));
    tick(1);
    check("lat_chars0", 64'(bus.chars[7:0]), 64'("A"));
    check("lat_upd", 64'(bus.upd), 64'(1));
    check("lat_idx", 64'(bus.upd_idx), 64'(0));
    check("lat_lost", 64'(bus.lost), 64'(0));
    tick(13);
    for (int d = 1; d < D; d++) begin
      logic [6:0] p [6];
      p = '{7'h77, 7'h38, 7'h37, 7'h77, 7'h78, 7'h6E};
      pins(d, p[d]);
      tick(20);
    end
    idle();
    tick(10);
    check("f1_chars", 64'(bus.chars), 64'(FRAME_CHARS));
    check("f1_valid", 64'(bus.valid), 64'(6'h3F));
    check("f1_lost", 64'(bus.lost), 64'(0));
    check("f1_upd_cnt", 64'(upd_cnt), 64'(6));
    check("f1_log_size", 64'(idx_log.size()), 64'(6));
    for (int i = 0; i < idx_log.size(); i++)
      check($sformatf("f1_idx%0d", i), 64'(idx_log[i]), 64'(i));

    base = upd_cnt;
    frame();
    check("f2_upd_cnt", 64'(upd_cnt), 64'(base));
    check("f2_chars", 64'(bus.chars), 64'(FRAME_CHARS));

    for (int k = 0; k < 20; k++) begin
      pins(2, (k % 3 == 2) ? 7'h7F : 7'h3F);
      tick(1);
    end
    idle();
    tick(10);
    check("glitch_upd_cnt", 64'(upd_cnt), 64'(base));
    check("glitch_chars2", 64'(bus.chars[23:16]), 64'("?"));

    bus.scan_sel = ~6'b000011;
    bus.scan_seg = ~7'h3F;
    tick(30);
    idle();
    tick(5);
    check("dual_upd_cnt", 64'(upd_cnt), 64'(base));
    check("dual_chars", 64'(bus.chars), 64'(FRAME_CHARS));
    check("dual_lost", 64'(bus.lost), 64'(0));

    pins(0, 7'h77);
    tick(7);
    check("reacc_upd", 64'(bus.upd), 64'(0));
    idle();
    tick(TO - 1);
    check("to_pre_lost", 64'(bus.lost), 64'(0));
    check("to_pre_valid", 64'(bus.valid), 64'(6'h3F));
    tick(1);
    check("to_lost", 64'(bus.lost), 64'(1));
    check("to_valid", 64'(bus.valid), 64'(0));
    check("to_chars", 64'(bus.chars), 64'(FRAME_CHARS));
    check("to_upd_cnt", 64'(upd_cnt), 64'(base));

    pins(0, 7'h3F);
    tick(7);
    check("res_lost", 64'(bus.lost), 64'(0));
    check("res_chars", 64'(bus.chars), 64'(48'h7974_413F_4C30));
    check("res_upd", 64'(bus.upd), 64'(1));
    check("res_idx", 64'(bus.upd_idx), 64'(0));
    check("res_valid", 64'(bus.valid), 64'(6'h01));
    idle();
    tick(10);

    base = upd_cnt;
    pins(1, 7'h06);
    tick(5);
    rst_n = 1'b0;
    #1;
    check("mid_chars", 64'(bus.chars), 64'(BLANK));
    check("mid_valid", 64'(bus.valid), 64'(0));
    check("mid_lost", 64'(bus.lost), 64'(1));
    check("mid_upd", 64'(bus.upd), 64'(0));
    check("mid_upd_idx", 64'(bus.upd_idx), 64'(0));
    idle();
    tick(2);
    rst_n = 1'b1;
    tick(20);
    check("post_upd_cnt", 64'(upd_cnt), 64'(base));
    check("post_chars", 64'(bus.chars), 64'(BLANK));
    check("post_valid", 64'(bus.valid), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
